reg_control_unit: RTL and testbench
===================================

# reg_control_unit

Multi-cycle control sequencer that acts as the initiator side of the 8×8-bit register file. It accepts 16-bit instructions over a valid/ready handshake, decodes them, and drives the register file's two read addresses. It also computes an 8-bit ALU result and issues the single-cycle write (address, data, enable) back into the file. It sits between the instruction source and the register file in the 8-bit processor datapath.

## Interface
- No parameters. Widths are fixed: 8-bit data, 3-bit register address, 16-bit instruction.
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr` input 16: instruction word; sampled only on a handshake.
- `instr_valid` input 1: the source has a valid instruction on `instr`.
- `instr_ready` output 1: the block accepts an instruction this cycle.
- `rf_rs1` output 3: register file read address 1.
- `rf_rs2` output 3: register file read address 2.
- `rf_rs1_data` input 8: combinational read data for `rf_rs1`.
- `rf_rs2_data` input 8: combinational read data for `rf_rs2`.
- `rf_we` output 1: register file write enable.
- `rf_rd` output 3: register file write address.
- `rf_wdata` output 8: register file write data.
- `flag_z` output 1: zero flag.
- `flag_c` output 1: carry/borrow flag.
- `halted` output 1: a HALT instruction was executed.
- `illegal` output 1: sticky; set when an undefined opcode is seen.

## Operation
- Instruction format:
  - [15:12] opcode.
  - [11:9] rd.
  - [8:6] rs1.
  - [5:3] rs2.
  - [7:0] imm8 (LI only; overlaps the rs fields).
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD: rd = rs1 + rs2.
  - 0x2 SUB: rd = rs1 − rs2.
  - 0x3 AND.
  - 0x4 OR.
  - 0x5 XOR.
  - 0x6 MOV: rd = rs1.
  - 0x7 LI: rd = imm8.
  - 0xF HALT.
  - 0x8–0xE are illegal.
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`: latch `instr` into the instruction register (IR) and go to DECODE. Otherwise stay.
- DECODE:
  - `rf_rs1`/`rf_rs2` driven from IR[8:6]/IR[5:3].
  - Read data is captured into operand registers A and B at the end of the cycle.
  - Go to EXECUTE.
- EXECUTE:
  - Compute the 9-bit result from A and B.
  - Register result[7:0] into the result register; update flags.
  - ALU ops and LI/MOV go to WRITEBACK.
  - NOP and illegal opcodes go to FETCH.
  - HALT goes to HALT.
- WRITEBACK:
  - `rf_we`=1 for exactly one cycle, with `rf_rd`=IR[11:9] and `rf_wdata`=result register.
  - Go to FETCH.
- HALT:
  - Terminal state: `halted`=1, `instr_ready`=0, `rf_we`=0.
  - Left only by reset.
- Arithmetic:
  - ADD: {c, r} = {0,A} + {0,B}; flag_c = bit 8.
  - SUB: r = A − B mod 256; flag_c = 1 iff A < B (borrow).
  - Logic ops, MOV and LI leave `flag_c` unchanged.
  - `flag_z` = (r == 0) for opcodes 0x1–0x7; unchanged for NOP, HALT and illegal.
- Writing any of r0–r7 is permitted; no register is hardwired.
- Illegal opcode: `illegal` is set, stays 1 until reset, and there is no writeback.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - State FETCH; IR, A, B and result = 0.
  - `rf_we`=0, `flag_z`=0, `flag_c`=0, `halted`=0, `illegal`=0.
  - `instr_ready`=1 after reset is released.
- `rf_rs1`/`rf_rs2` decode from IR in every state, so they are 0 out of reset.
- Latency from handshake edge:
  - The write is visible at the register file on the 3rd rising edge after the handshake edge.
  - A write instruction takes 4 cycles; NOP/illegal take 3.
- `instr_ready` is high only in FETCH. The source must hold `instr` and `instr_valid` until the handshake.
- Back-to-back dependency: an instruction's WRITEBACK commits before the next instruction's DECODE samples the file, so there is no hazard and no forwarding.
- Reset asserted mid-instruction:
  - The instruction is abandoned and `rf_we` drops immediately.
  - No partial write occurs after reset.

## Structure
- Shared package `cpu_pkg`: opcode localparams (OP_NOP … OP_HALT), FSM state encoding, and the instruction field bit positions.
- One natural sub-module, `alu8`: combinational; takes A, B, imm8 and opcode; produces the 8-bit result, carry and zero.
- The FSM, IR, operand registers and flags stay in `reg_control_unit`.

## Test plan
- Reset then LI r3,0x5A: `rf_we` pulses one cycle with rd=3, wdata=0x5A; flag_z=0; 4 cycles handshake-to-next-`instr_ready`.
- With r1=0xF0 and r2=0x20 (preloaded by LI), issue ADD r4,r1,r2: wdata=0x10, flag_c=1, flag_z=0.
- With r1=0x05 and r2=0x05, issue SUB r5,r1,r2: wdata=0x00, flag_z=1, flag_c=0.
- With r1=0x03 and r2=0x04, issue SUB: wdata=0xFF and flag_c=1.
- Issue opcode 0x9 then NOP: no `rf_we` for either; `illegal`=1 sticky; flags unchanged; `instr_ready` returns after 3 cycles.
- Dependency: LI r1,0x07 immediately followed by MOV r2,r1: second write has wdata=0x07.
- HALT while `instr_valid` is held high: `halted`=1 and `instr_ready` stays 0 for 20 cycles. Assert `rst_n`=0 during a WRITEBACK: `rf_we` falls asynchronously and all outputs reach their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit control sequencer: opcode values,
// FSM state encoding, instruction field positions and a small decode helper.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 16;

  // Instruction field bit positions
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 9;
  localparam int unsigned RS1_HI = 8;
  localparam int unsigned RS1_LO = 6;
  localparam int unsigned RS2_HI = 5;
  localparam int unsigned RS2_LO = 3;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  // Opcodes 0x1..0x7 produce a register write and update the zero flag.
  function automatic logic is_write_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LI);
  endfunction

  // Only ADD and SUB produce a carry/borrow.
  function automatic logic is_carry_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU.
// Ports:
//   a_i, b_i   : operands (from operand registers A and B)
//   imm8_i     : immediate for LI
//   op_i       : 4-bit opcode
//   result_o   : 8-bit result
//   carry_o    : bit 8 of the 9-bit result (carry for ADD, borrow for SUB)
//   zero_o     : result_o == 0
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] imm8_i,
  input  logic [3:0] op_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [8:0] res9;

  always_comb begin
    res9 = '0;
    case (op_i)
      // A 9-bit subtraction wraps to set bit 8 exactly when A < B.
      OP_ADD:  res9 = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  res9 = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  res9 = {1'b0, a_i & b_i};
      OP_OR:   res9 = {1'b0, a_i | b_i};
      OP_XOR:  res9 = {1'b0, a_i ^ b_i};
      OP_MOV:  res9 = {1'b0, a_i};
      OP_LI:   res9 = {1'b0, imm8_i};
      default: res9 = '0;
    endcase
  end

  assign result_o = res9[7:0];
  assign carry_o  = res9[8];
  assign zero_o   = (res9[7:0] == 8'h00);

endmodule

// File: rtl/reg_control_unit.sv
// Multi-cycle control sequencer driving an 8x8-bit register file.
// FETCH -> DECODE -> EXECUTE -> WRITEBACK (write ops) / FETCH (NOP, illegal) / HALT.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   instr, instr_valid        : instruction word and valid (held until handshake)
//   instr_ready               : high only in FETCH
//   rf_rs1, rf_rs2            : read addresses, decoded from IR in every state
//   rf_rs1_data, rf_rs2_data  : combinational read data
//   rf_we, rf_rd, rf_wdata    : single-cycle write port (WRITEBACK only)
//   flag_z, flag_c            : zero and carry/borrow flags
//   halted                    : HALT executed (terminal until reset)
//   illegal                   : sticky undefined-opcode indicator
module reg_control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  rf_rs1,
  output logic [2:0]  rf_rs2,
  input  logic [7:0]  rf_rs1_data,
  input  logic [7:0]  rf_rs2_data,
  output logic        rf_we,
  output logic [2:0]  rf_rd,
  output logic [7:0]  rf_wdata,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  res_q, res_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic        ill_q, ill_d;

  logic [3:0]  opcode;
  logic [7:0]  alu_res;
  logic        alu_c;
  logic        alu_z;

  assign opcode = ir_q[OPC_HI:OPC_LO];

  alu8 u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .imm8_i   (ir_q[IMM_HI:IMM_LO]),
    .op_i     (opcode),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    ill_d   = ill_q;

    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rs1_data;
        b_d     = rf_rs2_data;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        res_d = alu_res;
        if (is_write_op(opcode)) begin
          z_d     = alu_z;
          state_d = S_WRITEBACK;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          if (opcode != OP_NOP) ill_d = 1'b1;
          state_d = S_FETCH;
        end
        if (is_carry_op(opcode)) c_d = alu_c;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Outputs decode straight from the state register so that an asserted
  // reset drops rf_we without waiting for a clock edge.
  assign instr_ready = (state_q == S_FETCH);
  assign rf_we       = (state_q == S_WRITEBACK);
  assign halted      = (state_q == S_HALT);
  assign rf_rs1      = ir_q[RS1_HI:RS1_LO];
  assign rf_rs2      = ir_q[RS2_HI:RS2_LO];
  assign rf_rd       = ir_q[RD_HI:RD_LO];
  assign rf_wdata    = res_q;
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_reg_control_unit.sv
module tb_reg_control_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  rf_rs1, rf_rs2, rf_rd;
  logic [7:0]  rf_rs1_data, rf_rs2_data, rf_wdata;
  logic        rf_we, flag_z, flag_c, halted, illegal;

  logic [7:0]  mem [8];
  int          cyc, wr_cyc, hs_cyc, we_cnt;
  logic [2:0]  last_rd;
  logic [7:0]  last_wdata;
  int          n_checks, n_errors;

  reg_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rs1_data = mem[rf_rs1];
  assign rf_rs2_data = mem[rf_rs2];

  // Register file model and write monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rf_we && rst_n) begin
      mem[rf_rd] <= rf_wdata;
      last_rd     = rf_rd;
      last_wdata  = rf_wdata;
      wr_cyc      = cyc;
      we_cnt      = we_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake one instruction; optionally wait for instr_ready to return and
  // report the number of cycles from the handshake edge to the next ready.
  task automatic issue(input logic [15:0] w, input bit wait_done, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("hs_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    hs_cyc      = cyc;
    instr_valid = 1'b0;
    lat         = 1;
    if (wait_done) begin
      for (int i = 0; i < 50 && !instr_ready; i++) begin
        @(posedge clk);
        #1;
        lat++;
      end
      if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    end
  endtask

  int lat, we0;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    wr_cyc      = 0;
    hs_cyc      = 0;
    we_cnt      = 0;
    last_rd     = '0;
    last_wdata  = '0;
    instr       = '0;
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    check("rst_ready",   instr_ready, 1);
    check("rst_we",      rf_we,       0);
    check("rst_z",       flag_z,      0);
    check("rst_c",       flag_c,      0);
    check("rst_halted",  halted,      0);
    check("rst_illegal", illegal,     0);
    check("rst_rs1",     rf_rs1,      0);
    check("rst_rs2",     rf_rs2,      0);

    // LI r3,0x5A
    we0 = we_cnt;
    issue(16'h765A, 1'b1, lat);
    check("li_we_count", we_cnt - we0, 1);
    check("li_rd",       last_rd,      3);
    check("li_wdata",    last_wdata,   8'h5A);
    check("li_z",        flag_z,       0);
    check("li_latency",  lat,          4);
    check("li_wr_edge",  wr_cyc - hs_cyc, 3);
    check("li_mem",      mem[3],       8'h5A);

    // ADD r4,r1,r2 with r1=F0, r2=20
    issue(16'h72F0, 1'b1, lat);
    issue(16'h7420, 1'b1, lat);
    issue(16'h1850, 1'b1, lat);
    check("add_rd",    last_rd,    4);
    check("add_wdata", last_wdata, 8'h10);
    check("add_c",     flag_c,     1);
    check("add_z",     flag_z,     0);

    // SUB r5,r1,r2 with 5-5
    issue(16'h7205, 1'b1, lat);
    issue(16'h7405, 1'b1, lat);
    issue(16'h2A50, 1'b1, lat);
    check("sub0_wdata", last_wdata, 8'h00);
    check("sub0_z",     flag_z,     1);
    check("sub0_c",     flag_c,     0);

    // SUB r5,r1,r2 with 3-4 (borrow)
    issue(16'h7203, 1'b1, lat);
    issue(16'h7404, 1'b1, lat);
    issue(16'h2A50, 1'b1, lat);
    check("subb_wdata", last_wdata, 8'hFF);
    check("subb_c",     flag_c,     1);
    check("subb_z",     flag_z,     0);

    // Illegal opcode 0x9 then NOP: no writes, sticky illegal, flags held
    we0 = we_cnt;
    issue(16'h9E50, 1'b1, lat);
    check("ill_latency", lat,     3);
    check("ill_flag",    illegal, 1);
    issue(16'h0000, 1'b1, lat);
    check("nop_latency", lat,     3);
    check("ill_sticky",  illegal, 1);
    check("ill_no_we",   we_cnt - we0, 0);
    check("ill_c_held",  flag_c,  1);
    check("ill_z_held",  flag_z,  0);

    // Back-to-back dependency: LI r1,7 then MOV r2,r1
    issue(16'h7207, 1'b1, lat);
    issue(16'h6440, 1'b1, lat);
    check("mov_rd",    last_rd,    2);
    check("mov_wdata", last_wdata, 8'h07);

    // XOR r6,r1,r2 -> 0; zero set, carry untouched from the earlier borrow
    issue(16'h5C50, 1'b1, lat);
    check("xor_wdata", last_wdata, 8'h00);
    check("xor_z",     flag_z,     1);
    check("xor_c",     flag_c,     1);

    // Reset asserted during WRITEBACK of LI r0,0xAA
    we0 = we_cnt;
    issue(16'h70AA, 1'b0, lat);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wb_we_before", rf_we,    1);
    check("wb_wdata",     rf_wdata, 8'hAA);
    rst_n = 1'b0;
    #1;
    check("arst_we",      rf_we,       0);
    check("arst_ready",   instr_ready, 1);
    check("arst_z",       flag_z,      0);
    check("arst_c",       flag_c,      0);
    check("arst_illegal", illegal,     0);
    check("arst_halted",  halted,      0);
    check("arst_wdata",   rf_wdata,    0);
    check("arst_rd",      rf_rd,       0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_no_write", we_cnt - we0, 0);
    check("arst_mem0",     mem[0],       8'h00);

    // HALT with instr_valid held high
    we0 = we_cnt;
    issue(16'hF000, 1'b0, lat);
    instr       = 16'h7111;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", halted,      1);
      check("halt_ready",  instr_ready, 0);
      @(posedge clk); #1;
    end
    check("halt_no_we", we_cnt - we0, 0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt_rst_halted", halted,      0);
    check("halt_rst_ready",  instr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
